// File: rtl/bitop_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bitop_stream_pkg
// Brief    : Register addresses, operator encoding and per-bit operator helper
//            shared by the bitop stream engine.
// Revision : 1.0 - initial release
// ============================================================================
package bitop_stream_pkg;

    localparam logic [2:0] ADDR_A_NFULL  = 3'd0;
    localparam logic [2:0] ADDR_B_NFULL  = 3'd1;
    localparam logic [2:0] ADDR_Y_NEMPTY = 3'd2;
    localparam logic [2:0] ADDR_Y_HEAD   = 3'd3;
    localparam logic [2:0] ADDR_PUSH_A   = 3'd4;
    localparam logic [2:0] ADDR_PUSH_B   = 3'd5;
    localparam logic [2:0] ADDR_OP_MODE  = 3'd6;
    localparam logic [2:0] ADDR_COUNT    = 3'd7;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_XNOR = 2'd3
    } op_mode_e;

    function automatic logic apply_op(input op_mode_e op, input logic a, input logic b);
        logic r;
        r = a ^ b;
        case (op)
            OP_XOR:  r = a ^ b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XNOR: r = ~(a ^ b);
            default: r = a ^ b;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bitop_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bitop_sync_fifo
// Brief    : Single-clock FIFO with occupancy counter; push-when-full and
//            pop-when-empty are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module bitop_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    // Depth 1 still needs a one-bit pointer; it simply never leaves zero.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bitop_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : bitop_stream_engine
// Brief    : Two operand FIFOs feed a run-time selectable bitwise operator
//            into a result FIFO, all behind an address-mapped rd/wr port.
//            Optional result counter at address 7: BITOP_RESULT_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bitop_stream_engine
    import bitop_stream_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int A_DEPTH = 2,
    parameter int B_DEPTH = 2,
    parameter int Y_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [2:0]        read_address,
    input  logic              read_en,
    output logic [DATA_W-1:0] read_data,
    output logic              read_rdy,
    input  logic [2:0]        write_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              write_en,
    output logic              write_rdy
);

    logic [DATA_W-1:0] a_head, b_head, y_head, y_data;
    logic              a_full, a_empty, b_full, b_empty, y_full, y_empty;
    logic              a_push, b_push, y_pop, compute_fire;
    logic              wr_fire, rd_fire;
    logic [DATA_W-1:0] count_val;
    logic              count_wr_rdy;
    op_mode_e          op_mode_q, op_mode_d;

    assign wr_fire = write_en && write_rdy;
    assign rd_fire = read_en && read_rdy;
    assign a_push  = wr_fire && (write_address == ADDR_PUSH_A);
    assign b_push  = wr_fire && (write_address == ADDR_PUSH_B);
    assign y_pop   = rd_fire && (read_address == ADDR_Y_HEAD);

    // Y full is the pre-edge flag, so a same-cycle host pop does not free a slot.
    assign compute_fire = !a_empty && !b_empty && !y_full;

    bitop_sync_fifo #(.WIDTH(DATA_W), .DEPTH(A_DEPTH)) u_fifo_a (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (a_push),
        .data_i  (write_data),
        .pop_i   (compute_fire),
        .head_o  (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    bitop_sync_fifo #(.WIDTH(DATA_W), .DEPTH(B_DEPTH)) u_fifo_b (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (b_push),
        .data_i  (write_data),
        .pop_i   (compute_fire),
        .head_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    bitop_sync_fifo #(.WIDTH(DATA_W), .DEPTH(Y_DEPTH)) u_fifo_y (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (compute_fire),
        .data_i  (y_data),
        .pop_i   (y_pop),
        .head_o  (y_head),
        .full_o  (y_full),
        .empty_o (y_empty)
    );

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign y_data[i] = apply_op(op_mode_q, a_head[i], b_head[i]);
    end

    always_comb begin
        op_mode_d = op_mode_q;
        if (wr_fire && (write_address == ADDR_OP_MODE)) begin
            op_mode_d = op_mode_e'(2'(write_data));
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_mode_q <= OP_XOR;
        end else begin
            op_mode_q <= op_mode_d;
        end
    end

`ifdef BITOP_RESULT_COUNT_EN
    logic [DATA_W-1:0] count_q, count_d;

    // Clear has priority over a coincident increment.
    always_comb begin
        count_d = count_q;
        if (wr_fire && (write_address == ADDR_COUNT)) begin
            count_d = '0;
        end else if (compute_fire) begin
            count_d = count_q + DATA_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_val    = count_q;
    assign count_wr_rdy = 1'b1;
`else
    assign count_val    = '0;
    assign count_wr_rdy = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        read_rdy  = 1'b1;
        case (read_address)
            ADDR_A_NFULL:  read_data = DATA_W'(!a_full);
            ADDR_B_NFULL:  read_data = DATA_W'(!b_full);
            ADDR_Y_NEMPTY: read_data = DATA_W'(!y_empty);
            ADDR_Y_HEAD: begin
                read_rdy  = !y_empty;
                read_data = y_empty ? '0 : y_head;
            end
            ADDR_OP_MODE:  read_data = DATA_W'(op_mode_q);
            ADDR_COUNT:    read_data = count_val;
            default:       read_data = '0;
        endcase
    end

    always_comb begin
        write_rdy = 1'b0;
        case (write_address)
            ADDR_PUSH_A:  write_rdy = !a_full;
            ADDR_PUSH_B:  write_rdy = !b_full;
            ADDR_OP_MODE: write_rdy = 1'b1;
            ADDR_COUNT:   write_rdy = count_wr_rdy;
            default:      write_rdy = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_bitop_stream_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitop_stream_engine
// Brief    : Directed self-checking bench for bitop_stream_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bitop_stream_engine;

    logic       CLK;
    logic       RST_N;
    logic [2:0] read_address;
    logic       read_en;
    logic [7:0] read_data;
    logic       read_rdy;
    logic [2:0] write_address;
    logic [7:0] write_data;
    logic       write_en;
    logic       write_rdy;

    int checks = 0;
    int errors = 0;

    bitop_stream_engine #(
        .DATA_W(8), .A_DEPTH(2), .B_DEPTH(2), .Y_DEPTH(4)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=ready", tag);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        read_en      = 1'b0;
        read_address = addr;
        #1;
        check(tag, 32'(read_data), exp);
    endtask

    task automatic wrdy(input logic [2:0] addr, input logic exp, input string tag);
        write_en      = 1'b0;
        write_address = addr;
        #1;
        check(tag, 32'(write_rdy), 32'(exp));
    endtask

    task automatic write(input logic [2:0] addr, input logic [7:0] data, input string tag);
        int n;
        n             = 0;
        write_address = addr;
        write_data    = data;
        write_en      = 1'b1;
        #1;
        while (!write_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!write_rdy) begin
            timeout(tag);
            write_en = 1'b0;
        end else begin
            tick();
            write_en = 1'b0;
        end
    endtask

    task automatic pop(input logic [7:0] exp, input string tag);
        int n;
        n            = 0;
        read_en      = 1'b0;
        read_address = 3'd3;
        #1;
        while (!read_rdy && n < 20) begin
            tick();
            n++;
        end
        if (!read_rdy) begin
            timeout(tag);
        end else begin
            check(tag, 32'(read_data), 32'(exp));
            read_en = 1'b1;
            tick();
            read_en = 1'b0;
        end
    endtask

    function automatic logic [7:0] av(input int i);
        return 8'(8'h10 + i);
    endfunction

    function automatic logic [7:0] bv(input int i);
        return 8'(8'hE0 + 3 * i);
    endfunction

    initial begin
        RST_N         = 1'b0;
        read_address  = 3'd0;
        read_en       = 1'b0;
        write_address = 3'd0;
        write_data    = 8'h00;
        write_en      = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();

        // Idle state after reset
        peek(3'd0, 32'd1, "rst_a_nfull");
        peek(3'd1, 32'd1, "rst_b_nfull");
        peek(3'd2, 32'd0, "rst_y_nempty");
        tick();
        peek(3'd3, 32'd0, "rst_y_head");
        check("rst_rdy3", 32'(read_rdy), 32'd0);
        wrdy(3'd4, 1'b1, "rst_wrdy4");
        tick();
        peek(3'd6, 32'd0, "rst_op_mode");
        peek(3'd7, 32'd0, "rst_count");
        wrdy(3'd1, 1'b0, "wrdy_unmapped");
        tick();

        // XOR latency: B written at edge n, result visible after edge n+1
        write(3'd4, 8'hA5, "xor_wa");
        write(3'd5, 8'h0F, "xor_wb");
        peek(3'd2, 32'd0, "lat_not_yet");
        tick();
        peek(3'd2, 32'd1, "lat_ready");
        pop(8'hAA, "xor_res");
        peek(3'd2, 32'd0, "xor_drained");

        // AND / OR / XNOR
        write(3'd6, 8'hFD, "and_mode");
        peek(3'd6, 32'd1, "mode_read_and");
        write(3'd4, 8'hF0, "and_wa");
        write(3'd5, 8'h3C, "and_wb");
        pop(8'h30, "and_res");
        write(3'd6, 8'h02, "or_mode");
        write(3'd4, 8'hF0, "or_wa");
        write(3'd5, 8'h3C, "or_wb");
        pop(8'hFC, "or_res");
        write(3'd6, 8'h03, "xnor_mode");
        write(3'd4, 8'hF0, "xnor_wa");
        write(3'd5, 8'h3C, "xnor_wb");
        pop(8'h33, "xnor_res");

        // Fill A with B empty, then stream through pointer wrap
        write(3'd6, 8'h00, "wrap_mode");
        for (int i = 0; i < 7; i++) begin
            write_address = 3'd4;
            write_data    = av(i);
            write_en      = 1'b1;
            #1;
            check($sformatf("afill_rdy%0d", i), 32'(write_rdy), (i < 2) ? 32'd1 : 32'd0);
            tick();
        end
        write_en = 1'b0;
        peek(3'd0, 32'd0, "a_full_flag");
        for (int k = 0; k < 6; k++) begin
            write(3'd5, bv(k), "wrap_wb");
            if (k == 0) begin
                wrdy(3'd4, 1'b0, "a_full_during_pop");
            end
            if (k < 5) begin
                write(3'd4, av(k + 2), "wrap_wa");
            end
            pop(av(k) ^ bv(k), $sformatf("wrap_res%0d", k));
        end
        write(3'd5, 8'h00, "wrap_tail_wb");
        pop(av(6), "wrap_tail_res");

        // Y full with A/B backlog: host pop does not let compute fire same edge
        write(3'd6, 8'h02, "full_mode");
        for (int k = 0; k < 6; k++) begin
            write(3'd4, 8'(8'h10 * k), "full_wa");
            write(3'd5, 8'(k), "full_wb");
        end
        tick();
        tick();
        tick();
        wrdy(3'd4, 1'b0, "full_a_rdy");
        wrdy(3'd5, 1'b0, "full_b_rdy");
        pop(8'h00, "full_res0");
        wrdy(3'd4, 1'b0, "no_bypass");
        tick();
        wrdy(3'd4, 1'b1, "fire_after_pop");
        for (int k = 1; k < 6; k++) begin
            pop(8'(8'h11 * k), $sformatf("full_res%0d", k));
        end

        // op_mode written on the compute edge: old mode (OR) used
        write(3'd4, 8'hF0, "mode_edge_wa");
        write(3'd5, 8'h3C, "mode_edge_wb");
        write(3'd6, 8'h01, "mode_edge_wm");
        write(3'd4, 8'hF0, "mode_new_wa");
        write(3'd5, 8'h3C, "mode_new_wb");
        pop(8'hFC, "mode_old_res");
        pop(8'h30, "mode_new_res");

        // Result counter
`ifdef BITOP_RESULT_COUNT_EN
        write(3'd7, 8'h00, "cnt_clr");
        peek(3'd7, 32'd0, "cnt_cleared");
`endif
        for (int k = 0; k < 5; k++) begin
            write(3'd4, 8'(k), "cnt_wa");
            write(3'd5, 8'h01, "cnt_wb");
            pop(8'(k & 1), "cnt_res");
        end
`ifdef BITOP_RESULT_COUNT_EN
        peek(3'd7, 32'd5, "cnt_five");
        wrdy(3'd7, 1'b1, "cnt_wrdy");
        write(3'd4, 8'h01, "cnt_race_wa");
        write(3'd5, 8'h01, "cnt_race_wb");
        write(3'd7, 8'h00, "cnt_race_clr");
        peek(3'd7, 32'd0, "cnt_clear_wins");
        pop(8'h01, "cnt_race_res");
`else
        peek(3'd7, 32'd0, "cnt_absent");
        wrdy(3'd7, 1'b0, "cnt_wrdy_absent");
`endif

        // Mid-stream reset
        write(3'd4, 8'h55, "mr_wa");
        write(3'd5, 8'hAA, "mr_wb");
        write(3'd6, 8'h03, "mr_wm");
        write(3'd4, 8'h77, "mr_wa2");
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        peek(3'd0, 32'd1, "mr_a_nfull");
        peek(3'd1, 32'd1, "mr_b_nfull");
        peek(3'd2, 32'd0, "mr_y_nempty");
        tick();
        peek(3'd3, 32'd0, "mr_y_head");
        check("mr_rdy3", 32'(read_rdy), 32'd0);
        peek(3'd6, 32'd0, "mr_op_mode");
        peek(3'd7, 32'd0, "mr_count");
        tick();
        wrdy(3'd4, 1'b1, "mr_wrdy4");
        wrdy(3'd5, 1'b1, "mr_wrdy5");
        wrdy(3'd6, 1'b1, "mr_wrdy6");
        tick();
        write(3'd4, 8'h3C, "mr_post_wa");
        write(3'd5, 8'h0F, "mr_post_wb");
        pop(8'h33, "mr_post_res");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
